timer_ctrl: RTL

Sequencing core of the timer peripheral. It consumes the configuration and state registers held in the timer register file (PRE, ARE, CLR, ENA, MOD, CNT, EVN, EVC) and produces their next values every cycle. The register file stores CNT/EVN/EVC/CLR; bus writes to those registers override this block's next-value outputs in the register file. The block owns the prescaler, the run/one-shot state machine, event generation and the interrupt pulse.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_prescaler.sv | 25 ++
 rtl/timer_ctrl.sv | 77 +++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared types, width default and register map of the timer peripheral.
package timer_pkg;

    localparam int TIMER_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] OFF_PRE = 8'h00;
    localparam logic [7:0] OFF_ARE = 8'h04;
    localparam logic [7:0] OFF_CLR = 8'h08;
    localparam logic [7:0] OFF_ENA = 8'h0C;
    localparam logic [7:0] OFF_MOD = 8'h10;
    localparam logic [7:0] OFF_CNT = 8'h14;
    localparam logic [7:0] OFF_EVN = 8'h18;
    localparam logic [7:0] OFF_EVC = 8'h1C;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides running cycles by pre+1 and flags the tick cycle.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run,
    input  logic             clear,
    input  logic [WIDTH-1:0] pre,
    output logic             tick
);

    logic [WIDTH-1:0] pre_cnt;

    assign tick = run && (pre_cnt == pre);

    // A lowered pre below pre_cnt simply wraps through zero before matching again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pre_cnt <= '0;
        else         pre_cnt <= (!run || clear || tick) ? '0 : pre_cnt + 1'b1;
    end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: run/one-shot sequencer producing next CNT/EVN/EVC/CLR values and the irq pulse.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] tim_pre_i,
    input  logic [WIDTH-1:0] tim_are_i,
    input  logic             tim_clr_i,
    input  logic             tim_ena_i,
    input  logic             tim_mod_i,
    input  logic [WIDTH-1:0] tim_cnt_i,
    input  logic [WIDTH-1:0] tim_evn_i,
    input  logic             tim_evc_i,
    output logic [WIDTH-1:0] tim_cnt_o,
    output logic [WIDTH-1:0] tim_evn_o,
    output logic             tim_evc_o,
    output logic             tim_clr_o,
    output logic             irq_o,
    output logic             busy_o
);

    state_t state, state_nxt;
    logic   run, clr, tick, evt, irq_q;

    // Clear is ignored under reset so the next-value outputs stay pass-through.
    assign clr       = tim_clr_i && rst_ni;
    assign run       = (state == RUN) && tim_ena_i;
    assign evt       = tick && !clr && (tim_cnt_i >= tim_are_i);
    assign busy_o    = (state == RUN);
    assign irq_o     = irq_q;
    assign tim_clr_o = 1'b0;

    timer_prescaler #(.WIDTH(WIDTH)) u_pre (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .run    (run),
        .clear  (clr),
        .pre    (tim_pre_i),
        .tick   (tick)
    );

    always_comb begin
        state_nxt = state;
        tim_cnt_o = tim_cnt_i;
        tim_evn_o = tim_evn_i;
        tim_evc_o = tim_evc_i;
        if (clr) begin
            tim_cnt_o = '0;
            tim_evn_o = '0;
            tim_evc_o = 1'b0;
        end else if (tick) begin
            tim_cnt_o = evt ? '0 : tim_cnt_i + 1'b1;
            tim_evn_o = evt ? tim_evn_i + 1'b1 : tim_evn_i;
            tim_evc_o = evt ? 1'b1 : tim_evc_i;
        end
        case (state)
            IDLE:    state_nxt = tim_ena_i ? RUN : IDLE;
            RUN:     state_nxt = !tim_ena_i ? IDLE : (evt && !tim_mod_i) ? DONE : RUN;
            DONE:    state_nxt = (!tim_ena_i || clr) ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            irq_q <= 1'b0;
        end else begin
            state <= state_nxt;
            irq_q <= evt;
        end
    end

endmodule
